// File: rtl/audioram_responder.sv
// Audio buffer RAM responder: arbitrates audio reads, host accesses and zero-fill
// onto one 8K x 16 single-port RAM with a registered output, one access in flight.
module audioram_responder #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned FILL_LEN_W = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_rd,
    output logic [15:0]           mem_data,
    output logic                  mem_ack,
    output logic                  mem_ack_q,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [1:0]            host_be,
    input  logic [15:0]           host_wdata,
    output logic [15:0]           host_rdata,
    output logic                  host_ack,
    input  logic                  fill_start,
    input  logic [ADDR_W-1:0]     fill_addr,
    input  logic [FILL_LEN_W-1:0] fill_len,
    output logic                  fill_busy,
    output logic                  fill_done
);

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned DEPTH      = 2 ** ADDR_W;
    localparam int unsigned STARVE_W   = 3;
    localparam int unsigned STARVE_MAX = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_AUDIO, OWN_HOST, OWN_FILL} owner_t;

    state_t state, state_next;
    owner_t grant, op_owner;

    logic [ADDR_W-1:0]     sel_addr, op_addr, fill_cur;
    logic [DATA_W-1:0]     sel_wdata, op_wdata, ram_q;
    logic [1:0]            sel_be, op_be;
    logic                  sel_we, op_we;
    logic                  issue_en, complete, fill_cand, host_force;
    logic [FILL_LEN_W-1:0] fill_cnt;
    logic [STARVE_W-1:0]   starve_cnt;

    logic [DATA_W-1:0] ram [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (grant != OWN_NONE) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Arbitration and per-state strobes. The requester sees its ack during the
    // IDLE cycle, so a level still high at the IDLE edge is already a new request.
    always_comb begin
        grant      = OWN_NONE;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_be     = 2'b00;
        sel_we     = 1'b0;
        issue_en   = (state == ST_ISSUE);
        complete   = (state == ST_WAIT);
        fill_cand  = fill_busy && (fill_cnt != '0);
        host_force = (starve_cnt >= STARVE_W'(STARVE_MAX));
        if (state == ST_IDLE) begin
            if (host_req && host_force) grant = OWN_HOST;
            else if (mem_rd)            grant = OWN_AUDIO;
            else if (host_req)          grant = OWN_HOST;
            else if (fill_cand)         grant = OWN_FILL;
        end
        case (grant)
            OWN_AUDIO: sel_addr = mem_addr;
            OWN_HOST: begin
                sel_addr  = host_addr;
                sel_we    = host_we;
                sel_be    = host_be;
                sel_wdata = host_wdata;
            end
            OWN_FILL: begin
                sel_addr = fill_cur;
                sel_we   = 1'b1;
                sel_be   = 2'b11;
            end
            default: ;
        endcase
    end

    // Capture the winning access
    always_ff @(posedge clk) begin
        if (reset) begin
            op_owner <= OWN_NONE;
            op_addr  <= '0;
            op_wdata <= '0;
            op_be    <= 2'b00;
            op_we    <= 1'b0;
        end else if (grant != OWN_NONE) begin
            op_owner <= grant;
            op_addr  <= sel_addr;
            op_wdata <= sel_wdata;
            op_be    <= sel_be;
            op_we    <= sel_we;
        end
    end

    // RAM port with byte-lane writes and registered read data
    always_ff @(posedge clk) begin
        if (issue_en && !reset) begin
            if (op_we && op_be[0]) ram[op_addr][7:0]  <= op_wdata[7:0];
            if (op_we && op_be[1]) ram[op_addr][15:8] <= op_wdata[15:8];
            ram_q <= ram[op_addr];
        end
    end

    // Completion, acks, fill engine and host starvation tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_data   <= '0;
            mem_ack    <= 1'b0;
            mem_ack_q  <= 1'b0;
            host_rdata <= '0;
            host_ack   <= 1'b0;
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
            fill_cur   <= '0;
            fill_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            mem_ack   <= complete && (op_owner == OWN_AUDIO);
            mem_ack_q <= mem_ack;
            host_ack  <= complete && (op_owner == OWN_HOST);
            fill_done <= 1'b0;
            if (complete && op_owner == OWN_AUDIO) mem_data <= ram_q;
            if (complete && op_owner == OWN_HOST && !op_we) host_rdata <= ram_q;

            if (fill_start && !fill_busy) begin
                if (fill_len == '0) begin
                    fill_done <= 1'b1;
                end else begin
                    fill_busy <= 1'b1;
                    fill_cur  <= fill_addr;
                    fill_cnt  <= fill_len;
                end
            end else if (grant == OWN_FILL) begin
                fill_cur <= fill_cur + ADDR_W'(1);
                fill_cnt <= fill_cnt - FILL_LEN_W'(1);
            end
            if (complete && op_owner == OWN_FILL && fill_cnt == '0) begin
                fill_busy <= 1'b0;
                fill_done <= 1'b1;
            end

            if (grant == OWN_HOST) starve_cnt <= '0;
            else if (grant != OWN_NONE && host_req && !host_force)
                starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule
